// File: rtl/diff_pkg.sv
// Shared constants and types for the bit-difference link receiver.
package diff_pkg;

    localparam int unsigned DIFF_WIDTH = 32;
    localparam int unsigned DIFF_POS_W = 5;

    localparam logic [DIFF_WIDTH-1:0] DIFF_INIT = '0;

    typedef enum logic [0:0] {
        ST_ACCUM,
        ST_EMIT
    } diff_state_e;

endpackage

// File: rtl/pos_onehot_dec.sv
// Combinational one-hot decoder: bit position to toggle mask.
module pos_onehot_dec #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned POS_W = 5
) (
    input  logic [POS_W-1:0] pos,
    output logic [WIDTH-1:0] mask
);

    always_comb begin
        mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            mask[i] = (pos == POS_W'(i));
        end
    end

endmodule

// File: rtl/diff_patch_rx.sv
// Rebuilds each word by toggling received bit positions in the previously emitted word,
// then presents it over a valid/ready handshake.
module diff_patch_rx
    import diff_pkg::*;
#(
    parameter int unsigned     WIDTH = DIFF_WIDTH,
    parameter int unsigned     POS_W = DIFF_POS_W,
    parameter logic [WIDTH-1:0] INIT = WIDTH'(DIFF_INIT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [POS_W-1:0] in_pos,
    input  logic             in_last,
    input  logic             in_empty,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             err_order
);

    diff_state_e      state_q, state_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [POS_W-1:0] prev_pos_q, prev_pos_d;
    logic             first_q, first_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] mask;

    pos_onehot_dec #(
        .WIDTH (WIDTH),
        .POS_W (POS_W)
    ) u_dec (
        .pos  (in_pos),
        .mask (mask)
    );

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        work_d     = work_q;
        prev_pos_d = prev_pos_q;
        first_d    = first_q;
        err_d      = err_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_word   = base_q;

        case (state_q)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (!in_empty) begin
                        // Positions must strictly increase within a frame; no wrap-around.
                        if (first_q || (in_pos > prev_pos_q)) begin
                            work_d     = work_q ^ mask;
                            prev_pos_d = in_pos;
                            first_d    = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    if (in_last) begin
                        state_d = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                out_valid = 1'b1;
                out_word  = work_q;
                if (out_ready) begin
                    base_d  = work_q;
                    first_d = 1'b1;
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ACCUM;
            base_q     <= INIT;
            work_q     <= INIT;
            prev_pos_q <= '0;
            first_q    <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            work_q     <= work_d;
            prev_pos_q <= prev_pos_d;
            first_q    <= first_d;
            err_q      <= err_d;
        end
    end

    assign err_order = err_q;

endmodule

// File: tb/tb_diff_patch_rx.sv
// Scoreboard bench for diff_patch_rx: a frame-level model predicts each emitted word.
module tb_diff_patch_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_pos = '0;
    logic        in_last = 1'b0;
    logic        in_empty = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_word;
    logic        err_order;

    int checks = 0;
    int passes = 0;
    int ready_mode = 2;  // 0 random, 1 held low, 2 held high

    logic [32:0] exp_q[$];  // {err_order, word}
    logic [31:0] m_base = '0;
    bit          m_err = 1'b0;
    logic [4:0]  f_pos[16];
    bit          f_empty[16];

    diff_patch_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pos    (in_pos),
        .in_last   (in_last),
        .in_empty  (in_empty),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .err_order (err_order)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = ($urandom_range(0, 3) != 0);
            1: out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    // Monitor: every output transfer must match the oldest predicted frame.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {31'd0, out_valid, out_word}, 64'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("out_word", {32'd0, out_word}, {32'd0, e[31:0]});
                chk("err_order", {63'd0, err_order}, {63'd0, e[32]});
            end
        end
    end

    // Reference: XOR in every position that exceeds the highest one applied so far.
    task automatic model_frame(input int n);
        int          prev;
        logic [31:0] w;
        prev = -1;
        w = m_base;
        for (int i = 0; i < n; i++) begin
            if (!f_empty[i]) begin
                if (int'(f_pos[i]) > prev) begin
                    w = w ^ (32'd1 << f_pos[i]);
                    prev = int'(f_pos[i]);
                end else begin
                    m_err = 1'b1;
                end
            end
        end
        m_base = w;
        exp_q.push_back({m_err, w});
    endtask

    task automatic send_beat(input logic [4:0] p, input bit l, input bit e);
        int k;
        bit ok;
        in_valid = 1'b1;
        in_pos   = p;
        in_last  = l;
        in_empty = e;
        k  = 0;
        ok = 1'b0;
        while (!ok && k < 200) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            k++;
        end
        if (!ok) chk("beat_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (l) chk("latency_out_valid", {63'd0, out_valid}, 64'd1);
    endtask

    task automatic run_frame(input int n);
        model_frame(n);
        for (int i = 0; i < n; i++) send_beat(f_pos[i], (i == n - 1), f_empty[i]);
    endtask

    task automatic set_beats1(input logic [4:0] p, input bit e);
        f_pos[0] = p;
        f_empty[0] = e;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_word", {32'd0, out_word}, 64'd0);
        chk("rst_err_order", {63'd0, err_order}, 64'd0);
        exp_q.delete();
        m_base = '0;
        m_err  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int k;
        do_reset();

        set_beats1(5'd3, 1'b0);
        run_frame(1);

        f_pos[0] = 5'd0;  f_empty[0] = 1'b0;
        f_pos[1] = 5'd4;  f_empty[1] = 1'b0;
        f_pos[2] = 5'd31; f_empty[2] = 1'b0;
        run_frame(3);

        set_beats1(5'd17, 1'b1);
        run_frame(1);

        do_reset();
        f_pos[0] = 5'd5; f_empty[0] = 1'b0;
        f_pos[1] = 5'd2; f_empty[1] = 1'b0;
        run_frame(2);

        // Backpressure: word stays put and no beat is taken while out_ready is low.
        ready_mode = 1;
        @(posedge clk);
        #2;
        set_beats1(5'd7, 1'b0);
        run_frame(1);
        in_valid = 1'b1;
        in_pos   = 5'd9;
        in_last  = 1'b1;
        in_empty = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_out_word", {32'd0, out_word}, {32'd0, exp_q[0][31:0]});
        end
        ready_mode = 2;
        set_beats1(5'd9, 1'b0);
        run_frame(1);

        // Reset in the middle of a frame discards the partial word.
        send_beat(5'd4, 1'b0, 1'b0);
        send_beat(5'd6, 1'b0, 1'b0);
        do_reset();
        set_beats1(5'd1, 1'b0);
        run_frame(1);

        do_reset();
        ready_mode = 0;
        for (int f = 0; f < 40; f++) begin
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++) begin
                f_pos[i]   = 5'($urandom_range(0, 31));
                f_empty[i] = ($urandom_range(0, 7) == 0);
            end
            run_frame(n);
        end

        ready_mode = 2;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        chk("drain", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
